// File: rtl/mem_resp_pkg.sv
// Shared types for the memory burst responder: beat geometry, command entry
// layout and the read/write engine state encodings.
package mem_resp_pkg;

  localparam int unsigned BEAT_BYTES = 64;
  localparam int unsigned LINE_SHIFT = 6;

  typedef struct packed {
    logic [7:0]  len;
    logic [63:0] addr;
  } burst_cmd_t;

  typedef enum logic {
    RD_IDLE,
    RD_RUN
  } rd_state_e;

  typedef enum logic {
    WR_IDLE,
    WR_RUN
  } wr_state_e;

endpackage

// File: rtl/burst_cmd_fifo.sv
// Small command FIFO holding {len, addr} burst requests; DEPTH must be a
// power of two >= 2. Pointers carry one extra wrap bit to tell full from empty.
module burst_cmd_fifo
  import mem_resp_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  burst_cmd_t din_i,
  input  logic       pop_i,
  output burst_cmd_t dout_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = (PW + 1)'(1);

  burst_cmd_t  mem_q [DEPTH];
  logic [PW:0] wptr_q, wptr_d;
  logic [PW:0] rptr_q, rptr_d;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_i) wptr_d = wptr_q + PTR_ONE;
    if (pop_i)  rptr_d = rptr_q + PTR_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q[PW-1:0]] <= din_i;
  end

  assign dout_o  = mem_q[rptr_q[PW-1:0]];
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);

endmodule

// File: rtl/mem_burst_responder.sv
// Memory-side burst responder: queues read/write burst commands, streams
// 64-byte read beats from a line memory, absorbs write beats and returns bresp.
module mem_burst_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned MEM_AW     = 10,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rd_req,
  output logic                      rd_req_ack,
  input  logic [7:0]                rd_len,
  input  logic [63:0]               rd_address,
  output logic                      rd_data_valid,
  input  logic                      rd_data_ready,
  output logic [BEAT_BYTES*8-1:0]   rd_data,
  output logic                      rd_data_last,
  input  logic                      wr_req,
  output logic                      wr_req_ack,
  input  logic [7:0]                wr_len,
  input  logic [63:0]               wr_address,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [BEAT_BYTES*8-1:0]   wr_data,
  input  logic                      bready,
  output logic                      bresp,
  output logic                      idle
);

  localparam int unsigned DATA_W = BEAT_BYTES * 8;
  localparam int unsigned LINES  = 1 << MEM_AW;
  localparam int unsigned PEND_W = $clog2(FIFO_DEPTH) + 2;

  typedef logic [MEM_AW-1:0] idx_t;
  localparam idx_t              IDX_ONE  = idx_t'(1);
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [DATA_W-1:0] mem_q [LINES];

  // Command FIFOs
  burst_cmd_t rd_cmd_in, rd_head, wr_cmd_in, wr_head;
  logic       rd_full, rd_empty, rd_pop;
  logic       wr_full, wr_empty, wr_pop;
  idx_t       rd_head_idx, wr_head_idx;
  logic       unused_addr_bits;

  assign rd_cmd_in  = '{len: rd_len, addr: rd_address};
  assign wr_cmd_in  = '{len: wr_len, addr: wr_address};
  assign rd_req_ack = rd_req & ~rd_full;
  assign wr_req_ack = wr_req & ~wr_full;

  assign rd_head_idx = rd_head.addr[MEM_AW+LINE_SHIFT-1:LINE_SHIFT];
  assign wr_head_idx = wr_head.addr[MEM_AW+LINE_SHIFT-1:LINE_SHIFT];
  assign unused_addr_bits = ^{rd_head.addr[63:MEM_AW+LINE_SHIFT], rd_head.addr[LINE_SHIFT-1:0],
                              wr_head.addr[63:MEM_AW+LINE_SHIFT], wr_head.addr[LINE_SHIFT-1:0]};

  burst_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_rd_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (rd_req_ack),
    .din_i   (rd_cmd_in),
    .pop_i   (rd_pop),
    .dout_o  (rd_head),
    .full_o  (rd_full),
    .empty_o (rd_empty)
  );

  burst_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_wr_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (wr_req_ack),
    .din_i   (wr_cmd_in),
    .pop_i   (wr_pop),
    .dout_o  (wr_head),
    .full_o  (wr_full),
    .empty_o (wr_empty)
  );

  // Read engine
  rd_state_e         rd_state_q, rd_state_d;
  idx_t              rd_idx_q, rd_idx_d, rd_fetch_idx;
  logic [7:0]        rd_cnt_q, rd_cnt_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_last_q, rd_last_d;
  logic              rd_load, rd_out_free;
  logic [DATA_W-1:0] rd_data_q;

  assign rd_out_free = ~rd_valid_q | rd_data_ready;

  // The pop in RD_IDLE also loads the first beat, so ack->valid is two cycles
  // and a following burst streams with no bubble after the previous last beat.
  always_comb begin
    rd_state_d   = rd_state_q;
    rd_idx_d     = rd_idx_q;
    rd_cnt_d     = rd_cnt_q;
    rd_valid_d   = rd_valid_q;
    rd_last_d    = rd_last_q;
    rd_fetch_idx = rd_idx_q;
    rd_load      = 1'b0;
    rd_pop       = 1'b0;
    if (rd_out_free) begin
      rd_valid_d = 1'b0;
      rd_last_d  = 1'b0;
    end
    case (rd_state_q)
      RD_IDLE: begin
        if (rd_out_free && !rd_empty) begin
          rd_pop       = 1'b1;
          rd_load      = 1'b1;
          rd_fetch_idx = rd_head_idx;
          rd_last_d    = (rd_head.len == 8'd0);
          rd_idx_d     = rd_head_idx + IDX_ONE;
          rd_cnt_d     = rd_head.len - 8'd1;
          rd_state_d   = (rd_head.len == 8'd0) ? RD_IDLE : RD_RUN;
        end
      end
      RD_RUN: begin
        if (rd_out_free) begin
          rd_load   = 1'b1;
          rd_last_d = (rd_cnt_q == 8'd0);
          rd_idx_d  = rd_idx_q + IDX_ONE;
          rd_cnt_d  = rd_cnt_q - 8'd1;
          if (rd_cnt_q == 8'd0) rd_state_d = RD_IDLE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
    if (rd_load) rd_valid_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_q <= RD_IDLE;
      rd_idx_q   <= '0;
      rd_cnt_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_idx_q   <= rd_idx_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      if (rd_load) rd_data_q <= mem_q[rd_fetch_idx];
    end
  end

  assign rd_data_valid = rd_valid_q;
  assign rd_data_last  = rd_last_q;
  assign rd_data       = rd_data_q;

  // Write engine
  wr_state_e   wr_state_q, wr_state_d;
  idx_t        wr_idx_q, wr_idx_d;
  logic [7:0]  wr_cnt_q, wr_cnt_d;
  logic        wr_fire, pend_inc, bresp_w;
  logic [PEND_W-1:0] pend_q, pend_d;

  assign wr_ready = (wr_state_q == WR_RUN);
  assign wr_fire  = wr_valid & wr_ready;

  always_comb begin
    wr_state_d = wr_state_q;
    wr_idx_d   = wr_idx_q;
    wr_cnt_d   = wr_cnt_q;
    wr_pop     = 1'b0;
    pend_inc   = 1'b0;
    case (wr_state_q)
      WR_IDLE: begin
        if (!wr_empty && (pend_q != PEND_MAX)) begin
          wr_pop     = 1'b1;
          wr_idx_d   = wr_head_idx;
          wr_cnt_d   = wr_head.len;
          wr_state_d = WR_RUN;
        end
      end
      WR_RUN: begin
        if (wr_fire) begin
          wr_idx_d = wr_idx_q + IDX_ONE;
          wr_cnt_d = wr_cnt_q - 8'd1;
          if (wr_cnt_q == 8'd0) begin
            pend_inc   = 1'b1;
            wr_state_d = WR_IDLE;
          end
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  assign bresp_w = (pend_q != '0) & bready;

  always_comb begin
    pend_d = pend_q;
    case ({pend_inc, bresp_w})
      2'b10:   pend_d = pend_q + PEND_ONE;
      2'b01:   pend_d = pend_q - PEND_ONE;
      default: pend_d = pend_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_q <= WR_IDLE;
      wr_idx_q   <= '0;
      wr_cnt_q   <= '0;
      pend_q     <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_idx_q   <= wr_idx_d;
      wr_cnt_q   <= wr_cnt_d;
      pend_q     <= pend_d;
    end
  end

  // A same-cycle read of this line sees the old contents.
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_idx_q] <= wr_data;
  end

  assign bresp = bresp_w;
  assign idle  = rd_empty & wr_empty & (rd_state_q == RD_IDLE) & ~rd_valid_q &
                 (wr_state_q == WR_IDLE) & (pend_q == '0);

endmodule

// File: tb/tb_mem_burst_responder.sv
// Self-checking bench for mem_burst_responder: reference line memory plus a
// queue of expected read beats filled at each read ack.
module tb_mem_burst_responder;

  localparam int unsigned MEM_LINES = 1024;

  typedef struct {
    logic [511:0] data;
    logic         last;
  } beat_t;

  typedef struct {
    logic [7:0]  len;
    logic [63:0] addr;
    int unsigned line;
    int unsigned beats;
    int unsigned rmode;
  } rd_vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         rd_req, rd_req_ack, rd_data_valid, rd_data_ready, rd_data_last;
  logic [7:0]   rd_len, wr_len;
  logic [63:0]  rd_address, wr_address;
  logic [511:0] rd_data, wr_data;
  logic         wr_req, wr_req_ack, wr_valid, wr_ready, bready, bresp, idle;

  int unsigned  checks = 0, errors = 0;
  int unsigned  cyc = 0, beats = 0, lasts = 0, bresp_cnt = 0, last_beat_cyc = 0;
  int unsigned  ready_mode = 1;
  logic [511:0] mdl [MEM_LINES];
  beat_t        rd_q [$];
  rd_vec_t      vecs [7];

  mem_burst_responder #(.MEM_AW(10), .FIFO_DEPTH(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rd_req        (rd_req),
    .rd_req_ack    (rd_req_ack),
    .rd_len        (rd_len),
    .rd_address    (rd_address),
    .rd_data_valid (rd_data_valid),
    .rd_data_ready (rd_data_ready),
    .rd_data       (rd_data),
    .rd_data_last  (rd_data_last),
    .wr_req        (wr_req),
    .wr_req_ack    (wr_req_ack),
    .wr_len        (wr_len),
    .wr_address    (wr_address),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_data       (wr_data),
    .bready        (bready),
    .bresp         (bresp),
    .idle          (idle)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [511:0] pat(input int unsigned x);
    logic [511:0] p;
    for (int j = 0; j < 16; j++) p[j*32 +: 32] = x ^ (32'h01010101 * 32'(j));
    return p;
  endfunction

  // Sink ready: 0 = held low, 1 = held high, otherwise random
  initial begin
    rd_data_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       rd_data_ready = 1'b0;
        1:       rd_data_ready = 1'b1;
        default: rd_data_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Output monitor: compares each accepted read beat against the scoreboard
  always @(negedge clk) begin
    beat_t e;
    if (rst_n === 1'b1 && rd_data_valid && rd_data_ready) begin
      beats++;
      last_beat_cyc = cyc;
      if (rd_data_last) lasts++;
      if (rd_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected_beat actual=%0h required=none", rd_data);
      end else begin
        e = rd_q.pop_front();
        chk("rd_data", rd_data, e.data);
        chk("rd_last", rd_data_last, e.last);
      end
    end
    if (bresp) bresp_cnt++;
  end

  task automatic issue_read(input logic [7:0] len, input logic [63:0] addr, input int unsigned line,
                            input int unsigned tmo, output logic ok, output int unsigned ack_cyc);
    beat_t b;
    ok = 1'b0;
    ack_cyc = 0;
    rd_len = len;
    rd_address = addr;
    rd_req = 1'b1;
    for (int unsigned t = 0; t < tmo && !ok; t++) begin
      @(negedge clk);
      if (rd_req_ack) begin
        ok = 1'b1;
        ack_cyc = cyc;
        for (int unsigned k = 0; k <= 32'(len); k++) begin
          b.data = mdl[(line + k) % MEM_LINES];
          b.last = (k == 32'(len));
          rd_q.push_back(b);
        end
      end
      @(posedge clk); #1;
    end
    rd_req = 1'b0;
  endtask

  task automatic issue_write(input logic [7:0] len, input logic [63:0] addr, input int unsigned line,
                             input int unsigned seed, input logic chk_bresp);
    logic ok, got;
    int unsigned ack_cyc;
    ok = 1'b0;
    ack_cyc = 0;
    wr_len = len;
    wr_address = addr;
    wr_req = 1'b1;
    for (int unsigned t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (wr_req_ack) begin
        ok = 1'b1;
        ack_cyc = cyc;
      end
      @(posedge clk); #1;
    end
    wr_req = 1'b0;
    chk("wr_ack", ok, 1);
    if (!ok) return;
    for (int unsigned k = 0; k <= 32'(len); k++) begin
      wr_data = pat(seed + k);
      wr_valid = 1'b1;
      got = 1'b0;
      for (int unsigned t = 0; t < 50 && !got; t++) begin
        @(negedge clk);
        if (wr_ready) begin
          got = 1'b1;
          if (k == 0) chk("wr_ready_latency", cyc - ack_cyc, 2);
          mdl[(line + k) % MEM_LINES] = wr_data;
        end
        @(posedge clk); #1;
      end
      if (!got) chk("wr_beat_accepted", got, 1);
    end
    wr_valid = 1'b0;
    if (chk_bresp) begin
      @(negedge clk);
      chk("bresp_after_last", bresp, 1);
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_drain(input string nm);
    int unsigned t = 0;
    while ((rd_q.size() != 0 || idle !== 1'b1) && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    chk(nm, (rd_q.size() == 0) && (idle === 1'b1), 1);
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    int unsigned a1, a2, b0, l0, bc0, t;

    vecs[0] = '{8'd3,  64'h0,                  0,    4,  1};
    vecs[1] = '{8'd0,  64'h40,                 1,    1,  1};
    vecs[2] = '{8'd7,  64'hFFC0,               1023, 8,  1};
    vecs[3] = '{8'd2,  64'hFFFF_0000_0000_0080, 2,   3,  1};
    vecs[4] = '{8'd1,  64'h3F7F,               253,  2,  1};
    vecs[5] = '{8'd15, 64'h8000,               512,  16, 2};
    vecs[6] = '{8'd63, 64'hF000,               960,  64, 2};

    rst_n = 1'b0;
    rd_req = 1'b0; rd_len = '0; rd_address = '0;
    wr_req = 1'b0; wr_len = '0; wr_address = '0;
    wr_valid = 1'b0; wr_data = '0; bready = 1'b1;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_rd_req_ack", rd_req_ack, 0);
    chk("rst_wr_req_ack", wr_req_ack, 0);
    chk("rst_rd_valid", rd_data_valid, 0);
    chk("rst_rd_last", rd_data_last, 0);
    chk("rst_rd_data", rd_data, '0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_idle", idle, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Preload every line: line i holds pat(i)
    bc0 = bresp_cnt;
    for (int unsigned k = 0; k < 16; k++)
      issue_write(8'd63, 64'(k * 32'h1000), k * 64, k * 64, 1'b1);
    repeat (3) @(posedge clk); #1;
    chk("preload_bresp_count", bresp_cnt - bc0, 16);

    // Single read, latency and consecutive beats
    issue_read(8'd3, 64'h0, 0, 50, ok, a1);
    chk("single_ack", ok, 1);
    for (int unsigned k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("single_valid_timing", rd_data_valid, (k >= 2 && k <= 5));
      chk("single_last_timing", rd_data_last, (k == 5));
    end
    @(posedge clk); #1;
    wait_drain("single_drain");

    // 4KB split: back-to-back acks, 74 gap-free beats
    b0 = beats;
    l0 = lasts;
    issue_read(8'd63, 64'h0, 0, 50, ok, a1);
    chk("split_ack0", ok, 1);
    issue_read(8'd9, 64'h1000, 64, 50, ok, a2);
    chk("split_ack1", ok, 1);
    chk("split_ack_consecutive", a2 - a1, 1);
    wait_drain("split_drain");
    chk("split_beats", beats - b0, 74);
    chk("split_lasts", lasts - l0, 2);
    chk("split_throughput", last_beat_cyc - a1, 75);

    // Table of read bursts: address decode, wrap, len=0, sink backpressure
    for (int i = 0; i < 7; i++) begin
      ready_mode = vecs[i].rmode;
      b0 = beats;
      issue_read(vecs[i].len, vecs[i].addr, vecs[i].line, 50, ok, a1);
      chk("vec_ack", ok, 1);
      wait_drain("vec_drain");
      chk("vec_beats", beats - b0, vecs[i].beats);
    end
    ready_mode = 1;
    repeat (2) @(posedge clk); #1;

    // Write A,B to line 1..2 then read back
    bc0 = bresp_cnt;
    issue_write(8'd1, 64'h40, 1, 32'hA000_0000, 1'b1);
    repeat (3) @(posedge clk); #1;
    chk("wr_single_bresp", bresp_cnt - bc0, 1);
    issue_read(8'd1, 64'h40, 1, 50, ok, a1);
    chk("wr_readback_ack", ok, 1);
    wait_drain("wr_readback_drain");

    // Backpressure: FIFO_DEPTH+1 acks, then stall until the sink frees
    ready_mode = 0;
    repeat (2) @(posedge clk); #1;
    b0 = beats;
    for (int unsigned k = 0; k < 5; k++) begin
      issue_read(8'd1, 64'((k + 1) * 32'h1000 + 32'h80), (k + 1) * 64 + 2, 5, ok, a1);
      chk("bp_ack", ok, 1);
    end
    issue_read(8'd1, 64'h6080, 386, 20, ok, a1);
    chk("bp_stall_no_ack", ok, 0);
    chk("bp_no_beats_taken", beats - b0, 0);
    chk("bp_valid_held", rd_data_valid, 1);
    ready_mode = 1;
    issue_read(8'd1, 64'h6080, 386, 50, ok, a1);
    chk("bp_ack_after_release", ok, 1);
    wait_drain("bp_drain");
    chk("bp_beats", beats - b0, 12);

    // Wrap write at the top line with bready low
    bready = 1'b0;
    bc0 = bresp_cnt;
    issue_write(8'd1, 64'hFFC0, 1023, 32'hC000_0000, 1'b0);
    repeat (10) @(posedge clk); #1;
    chk("wrap_no_bresp", bresp_cnt - bc0, 0);
    chk("wrap_not_idle", idle, 0);
    bready = 1'b1;
    @(negedge clk);
    chk("wrap_bresp_on_bready", bresp, 1);
    repeat (3) @(posedge clk); #1;
    chk("wrap_single_bresp", bresp_cnt - bc0, 1);
    issue_read(8'd1, 64'hFFC0, 1023, 50, ok, a1);
    chk("wrap_read_ack", ok, 1);
    wait_drain("wrap_read_drain");
    issue_read(8'd0, 64'h0, 0, 50, ok, a1);
    chk("wrap_line0_ack", ok, 1);
    wait_drain("wrap_line0_drain");

    // Asynchronous reset during a long read burst
    b0 = beats;
    issue_read(8'd63, 64'h0, 0, 50, ok, a1);
    chk("arst_ack", ok, 1);
    t = 0;
    while (beats < b0 + 5 && t < 200) begin
      @(posedge clk);
      t++;
    end
    chk("arst_reached_beat5", beats - b0, 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rd_valid", rd_data_valid, 0);
    chk("arst_rd_last", rd_data_last, 0);
    chk("arst_rd_data", rd_data, '0);
    chk("arst_wr_ready", wr_ready, 0);
    chk("arst_bresp", bresp, 0);
    chk("arst_idle", idle, 1);
    rd_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int unsigned k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("arst_post_valid", rd_data_valid, 0);
      chk("arst_post_idle", idle, 1);
    end
    @(posedge clk); #1;
    b0 = beats;
    issue_read(8'd1, 64'h40, 1, 50, ok, a1);
    chk("arst_post_read_ack", ok, 1);
    wait_drain("arst_post_read_drain");
    chk("arst_post_read_beats", beats - b0, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
